// File: rtl/m2vcst_dispatch.sv
// Custom-instruction dispatcher: latches operands, issues a one-hot start/enable to the selected unit
// and returns its result as a single done/result pulse. Optional watchdog: define M2VCST_TIMEOUT_EN.
module m2vcst_dispatch #(
   parameter int                DATA_WIDTH     = 16,
   parameter int                CSEL_WIDTH     = 3,
   parameter int                NUNITS         = 8,
   parameter logic [NUNITS-1:0] UNIT_MASK      = 8'hFF,
   parameter int                TIMEOUT_CYCLES = 1023
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         softreset,
   input  logic [DATA_WIDTH-1:0]        s_adata,
   input  logic [DATA_WIDTH-1:0]        s_bdata,
   input  logic [CSEL_WIDTH-1:0]        s_select,
   input  logic                         s_start,
   input  logic                         s_enable,
   output logic [DATA_WIDTH-1:0]        s_result,
   output logic                         s_done,
   output logic [DATA_WIDTH-1:0]        u_adata,
   output logic [DATA_WIDTH-1:0]        u_bdata,
   output logic [NUNITS-1:0]            u_start,
   output logic [NUNITS-1:0]            u_enable,
   input  logic [NUNITS*DATA_WIDTH-1:0] u_result,
   input  logic [NUNITS-1:0]            u_done,
   output logic                         busy,
   output logic                         err_illegal,
   output logic                         err_timeout
);

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

   function automatic logic [NUNITS-1:0] onehot(input logic [CSEL_WIDTH-1:0] sel);
      logic [NUNITS-1:0] oh;
      for (int i = 0; i < NUNITS; i++) oh[i] = (sel == CSEL_WIDTH'(i));
      return oh;
   endfunction

   function automatic logic slot_ok(input logic [CSEL_WIDTH-1:0] sel);
      return |(onehot(sel) & UNIT_MASK);
   endfunction

   state_t                  state_r, state_nx_s;
   logic [CSEL_WIDTH-1:0]   sel_r, sel_nx_s;
   logic [DATA_WIDTH-1:0]   adata_r, adata_nx_s, bdata_r, bdata_nx_s;
   logic [DATA_WIDTH-1:0]   result_r, result_nx_s, result_sel_s;
   logic [NUNITS-1:0]       start_r, start_nx_s, enable_r, enable_nx_s;
   logic                    done_r, done_nx_s, done_sel_s;
   logic                    busy_r, err_ill_r, err_ill_nx_s, err_to_r, err_to_nx_s;
`ifdef M2VCST_TIMEOUT_EN
   localparam int               WD_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
   logic [WD_W-1:0]             wd_r, wd_nx_s;
`endif

   // Select the owning unit's result slice and done bit.
   always_comb begin
      result_sel_s = {DATA_WIDTH{1'b0}};
      for (int i = 0; i < NUNITS; i++) begin
         result_sel_s = result_sel_s |
                        (u_result[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{sel_r == CSEL_WIDTH'(i)}});
      end
      done_sel_s = |(u_done & onehot(sel_r));
   end

   // Next-state and next-output logic.
   always_comb begin
      state_nx_s   = state_r;
      sel_nx_s     = sel_r;
      adata_nx_s   = adata_r;
      bdata_nx_s   = bdata_r;
      result_nx_s  = result_r;
      start_nx_s   = {NUNITS{1'b0}};
      enable_nx_s  = enable_r;
      done_nx_s    = 1'b0;
      err_ill_nx_s = err_ill_r;
      err_to_nx_s  = err_to_r;
`ifdef M2VCST_TIMEOUT_EN
      wd_nx_s      = wd_r;
`endif
      case (state_r)
         IDLE: begin
            if (s_start) begin
               sel_nx_s   = s_select;
               adata_nx_s = s_adata;
               bdata_nx_s = s_bdata;
               state_nx_s = ISSUE;
`ifdef M2VCST_TIMEOUT_EN
               wd_nx_s    = {WD_W{1'b0}};
`endif
               if (slot_ok(s_select)) begin
                  start_nx_s  = onehot(s_select);
                  enable_nx_s = onehot(s_select);
               end else begin
                  // Illegal ops idle through the issue cycle so every op has the same minimum latency.
                  err_ill_nx_s = 1'b1;
                  result_nx_s  = {DATA_WIDTH{1'b0}};
               end
            end else begin
               state_nx_s = IDLE;
            end
         end
         ISSUE, WAIT: begin
            if (!s_enable) begin
               state_nx_s  = IDLE;
               enable_nx_s = {NUNITS{1'b0}};
            end else if (!slot_ok(sel_r)) begin
               state_nx_s = RESP;
               done_nx_s  = 1'b1;
            end else if (done_sel_s) begin
               state_nx_s  = RESP;
               done_nx_s   = 1'b1;
               result_nx_s = result_sel_s;
               enable_nx_s = {NUNITS{1'b0}};
            end
`ifdef M2VCST_TIMEOUT_EN
            else if ((state_r == WAIT) && (wd_r == WD_LAST)) begin
               state_nx_s  = RESP;
               done_nx_s   = 1'b1;
               result_nx_s = {DATA_WIDTH{1'b1}};
               enable_nx_s = {NUNITS{1'b0}};
               err_to_nx_s = 1'b1;
            end else begin
               state_nx_s = WAIT;
               wd_nx_s    = (state_r == WAIT) ? (wd_r + WD_W'(1'b1)) : wd_r;
            end
`else
            else begin
               state_nx_s = WAIT;
            end
`endif
         end
         RESP: begin
            state_nx_s = IDLE;
         end
         default: begin
            state_nx_s  = IDLE;
            enable_nx_s = {NUNITS{1'b0}};
         end
      endcase
   end

   // State and output registers; softreset has the same effect as reset_n.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n || softreset) begin
         state_r   <= IDLE;
         sel_r     <= {CSEL_WIDTH{1'b0}};
         adata_r   <= {DATA_WIDTH{1'b0}};
         bdata_r   <= {DATA_WIDTH{1'b0}};
         result_r  <= {DATA_WIDTH{1'b0}};
         start_r   <= {NUNITS{1'b0}};
         enable_r  <= {NUNITS{1'b0}};
         done_r    <= 1'b0;
         busy_r    <= 1'b0;
         err_ill_r <= 1'b0;
         err_to_r  <= 1'b0;
`ifdef M2VCST_TIMEOUT_EN
         wd_r      <= {WD_W{1'b0}};
`endif
      end else begin
         state_r   <= state_nx_s;
         sel_r     <= sel_nx_s;
         adata_r   <= adata_nx_s;
         bdata_r   <= bdata_nx_s;
         result_r  <= result_nx_s;
         start_r   <= start_nx_s;
         enable_r  <= enable_nx_s;
         done_r    <= done_nx_s;
         busy_r    <= (state_nx_s != IDLE);
         err_ill_r <= err_ill_nx_s;
         err_to_r  <= err_to_nx_s;
`ifdef M2VCST_TIMEOUT_EN
         wd_r      <= wd_nx_s;
`endif
      end
   end

   assign s_result    = result_r;
   assign s_done      = done_r;
   assign u_adata     = adata_r;
   assign u_bdata     = bdata_r;
   assign u_start     = start_r;
   assign u_enable    = enable_r;
   assign busy        = busy_r;
   assign err_illegal = err_ill_r;
   assign err_timeout = err_to_r;

endmodule
